decomp_dispatch: RTL
====================

# decomp_dispatch

Parametrised packet dispatcher for the decompression path. Decodes the engine tag in the top bits of each packet's SOP beat and latches the route for the whole packet. Routes every beat up to EOP to exactly one of NUM_ENG decompression engines. Merges engine outputs back into one stream in original packet order, using an order FIFO, so several packets can be in flight across different engines. Sits between the compressed-stream ingress and the downstream consumer, replacing the per-beat combinational mode mux.

## Interface
- DATA_W, 64, beat width (≥ TAG_W+1)
- NUM_ENG, 3, number of engines (2..2**TAG_W)
- TAG_W, 2, tag field width; tag = s_data_i[DATA_W-1 -: TAG_W]
- ORD_DEPTH, 4, packets in flight (power of 2, ≥2)

- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; asynchronous, active-high
- s_data_i / s_valid_i / s_sop_i / s_eop_i  in  DATA_W/1/1/1  compressed ingress beat
- s_ready_o  out  1  ingress accept
- eng_data_o  out  DATA_W  ingress data broadcast to all engines (unmodified)
- eng_valid_o / eng_sop_o / eng_eop_o  out  NUM_ENG each  per-engine qualifiers, one-hot or zero
- eng_ready_i  in  NUM_ENG  per-engine accept
- eng_rdata_i  in  NUM_ENG*DATA_W  engine results, engine k at [k*DATA_W +: DATA_W]
- eng_rvalid_i / eng_rsop_i / eng_reop_i  in  NUM_ENG each
- eng_rready_o  out  NUM_ENG  result accept, one-hot or zero
- m_data_o / m_valid_o / m_sop_o / m_eop_o  out  DATA_W/1/1/1  decompressed egress
- m_ready_i  in  1  egress accept
- err_drop_o  out  1  one-cycle pulse per dropped packet or stray beat
- busy_o  out  1  FSM not IDLE or order FIFO non-empty

## Operation
- Handshake rule: a beat transfers when valid && ready in the same cycle. Valid never depends on ready.
- Ingress FSM states: IDLE, ROUTE, DROP.
- IDLE, s_valid_i with s_sop_i:
  - tag < NUM_ENG and order FIFO not full: s_ready_o = eng_ready_i[tag] and the beat passes to engine tag.
  - On transfer: push tag into the order FIFO and store tag in sel_q.
  - If the beat has no EOP, go to ROUTE. If it is SOP+EOP, stay IDLE.
- IDLE, tag ≥ NUM_ENG: s_ready_o = 1. Pulse err_drop_o. Go to DROP unless EOP is set. Nothing is pushed.
- IDLE, valid tag but FIFO full: s_ready_o = 0; the beat stalls.
- IDLE, s_valid_i without SOP: s_ready_o = 1, beat discarded, err_drop_o pulses.
- ROUTE: beats go to engine sel_q and s_ready_o = eng_ready_i[sel_q]. A beat carrying SOP here is forwarded as data; the tag is not re-decoded. Return to IDLE on EOP transfer.
- DROP: s_ready_o = 1, beats discarded. Return to IDLE on EOP.
- Egress:
  - Order FIFO head h selects the source: m_* = eng_r*[h] and eng_rready_o[h] = m_ready_i.
  - Pop on the m_eop_o transfer.
  - FIFO empty: m_valid_o = 0 and eng_rready_o = 0.
  - Other engines stay back-pressured until their turn.
- Order FIFO count width is clog2(ORD_DEPTH)+1. Pointers wrap modulo ORD_DEPTH.
- Reset values: FSM = IDLE, FIFO empty, sel_q = 0, err_drop_o = 0, busy_o = 0.
  - All eng_valid_o / eng_rready_o / m_valid_o = 0.
  - s_ready_o follows the IDLE rules.
- Reset mid-packet aborts silently. Engines are reset by the same rst.

## Timing
- Ingress and egress data paths are combinational: zero added latency, full throughput of one beat per cycle each direction.
- FIFO push happens on the SOP transfer edge. The new head is visible to egress the next cycle.
- Push when full is blocked, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged.
- Push on an empty FIFO: egress sees the packet no earlier than the following cycle.
- err_drop_o is registered and asserts the cycle after the offending transfer.

## Structure
- Package decomp_pkg:
  - tag constants TAG_BPC=0, TAG_ZRL=1, TAG_SR=2
  - state enum {IDLE, ROUTE, DROP}
  - default DATA_W/TAG_W
- Sub-module decomp_ord_fifo: synchronous FIFO, width clog2(NUM_ENG), depth ORD_DEPTH, full/empty outputs.

## Test plan
- Single packets: tag 1 (ZRL), 3 beats, engine 1 echoes them → m_* reproduces the 3 beats, SOP on beat 0, EOP on beat 2. eng_valid_o[0] and eng_valid_o[2] never assert.
- Reordering: packet A to engine 2 (slow, 10-cycle delay), then packet B to engine 0 (immediate response) → egress emits A fully before B. eng_rready_o[0] stays 0 until A's EOP.
- Bad tag: tag 3 with NUM_ENG=3, 4-beat packet → all beats accepted, one err_drop_o pulse, no engine valid, FIFO count unchanged.
- Full FIFO: 5 one-beat packets with egress m_ready_i=0 → the 5th SOP stalls (s_ready_o=0) until one pop; then it is accepted.
- Back-to-back SOP+EOP single beats alternating tags 0/1/2 at 1 beat/cycle → 1 beat/cycle in and out, order preserved.
- Async reset asserted mid-ROUTE → the same cycle gives busy_o=0, m_valid_o=0, FSM IDLE. The next SOP routes correctly.

Source files
------------

// File: rtl/decomp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decomp_pkg
// Description : Shared tag codes, ingress FSM states and default widths for
//               the decompression dispatch path.
// Revision    : 1.0 - initial release
// ============================================================================
package decomp_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_TAG_W  = 2;

  localparam logic [1:0] TAG_BPC = 2'd0;
  localparam logic [1:0] TAG_ZRL = 2'd1;
  localparam logic [1:0] TAG_SR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/decomp_ord_fifo.sv
`default_nettype none
// ============================================================================
// Module      : decomp_ord_fifo
// Description : Synchronous FIFO holding the engine index of each packet in
//               flight; a push while full is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module decomp_ord_fifo
  import decomp_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/decomp_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : decomp_dispatch
// Description : Routes whole packets to decompression engines by SOP tag and
//               merges engine results back in original packet order.
// Revision    : 1.0 - initial release
// ============================================================================
module decomp_dispatch
  import decomp_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_ENG   = 3,
  parameter int TAG_W     = DEFAULT_TAG_W,
  parameter int ORD_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         s_data_i,
  input  logic                      s_valid_i,
  input  logic                      s_sop_i,
  input  logic                      s_eop_i,
  output logic                      s_ready_o,
  output logic [DATA_W-1:0]         eng_data_o,
  output logic [NUM_ENG-1:0]        eng_valid_o,
  output logic [NUM_ENG-1:0]        eng_sop_o,
  output logic [NUM_ENG-1:0]        eng_eop_o,
  input  logic [NUM_ENG-1:0]        eng_ready_i,
  input  logic [NUM_ENG*DATA_W-1:0] eng_rdata_i,
  input  logic [NUM_ENG-1:0]        eng_rvalid_i,
  input  logic [NUM_ENG-1:0]        eng_rsop_i,
  input  logic [NUM_ENG-1:0]        eng_reop_i,
  output logic [NUM_ENG-1:0]        eng_rready_o,
  output logic [DATA_W-1:0]         m_data_o,
  output logic                      m_valid_o,
  output logic                      m_sop_o,
  output logic                      m_eop_o,
  input  logic                      m_ready_i,
  output logic                      err_drop_o,
  output logic                      busy_o
);

  localparam int ENG_W = $clog2(NUM_ENG);

  state_t             r_state, w_state_nxt;
  logic [ENG_W-1:0]   r_sel, w_sel_nxt;
  logic [ENG_W-1:0]   w_tag_idx, w_head;
  logic [TAG_W-1:0]   w_tag;
  logic               w_tag_ok;
  logic [NUM_ENG-1:0] w_tag_oh, w_sel_oh, w_head_oh, w_eng_valid;
  logic               w_ready, w_push, w_pop, w_drop;
  logic               w_full, w_empty;
  logic               r_err_drop;

  assign w_tag     = s_data_i[DATA_W-1 -: TAG_W];
  assign w_tag_ok  = (32'(w_tag) < NUM_ENG);
  assign w_tag_idx = w_tag[ENG_W-1:0];

  always_comb begin
    w_tag_oh  = '0;
    w_sel_oh  = '0;
    w_head_oh = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      w_tag_oh[k]  = (32'(w_tag_idx) == k);
      w_sel_oh[k]  = (32'(r_sel) == k);
      w_head_oh[k] = (32'(w_head) == k);
    end
  end

  // Ingress FSM: route decision is taken only on the SOP beat in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_eng_valid = '0;
    w_ready     = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (s_sop_i && w_tag_ok) begin
          if (!w_full) begin
            w_ready     = |(eng_ready_i & w_tag_oh);
            w_eng_valid = s_valid_i ? w_tag_oh : '0;
            if (s_valid_i && w_ready) begin
              w_push    = 1'b1;
              w_sel_nxt = w_tag_idx;
              if (!s_eop_i) w_state_nxt = ROUTE;
            end
          end
        end else begin
          w_ready = 1'b1;
          w_drop  = s_valid_i;
          if (s_valid_i && s_sop_i && !s_eop_i) w_state_nxt = DROP;
        end
      end
      ROUTE: begin
        w_ready     = |(eng_ready_i & w_sel_oh);
        w_eng_valid = s_valid_i ? w_sel_oh : '0;
        if (s_valid_i && w_ready && s_eop_i) w_state_nxt = IDLE;
      end
      DROP: begin
        w_ready = 1'b1;
        if (s_valid_i && s_eop_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_err_drop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_err_drop <= w_drop;
    end
  end

  assign s_ready_o   = w_ready;
  assign eng_data_o  = s_data_i;
  assign eng_valid_o = w_eng_valid;
  assign eng_sop_o   = w_eng_valid & {NUM_ENG{s_sop_i}};
  assign eng_eop_o   = w_eng_valid & {NUM_ENG{s_eop_i}};
  assign err_drop_o  = r_err_drop;
  assign busy_o      = (r_state != IDLE) || !w_empty;

  decomp_ord_fifo #(
    .WIDTH (ENG_W),
    .DEPTH (ORD_DEPTH)
  ) u_ord_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_tag_idx),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Egress follows the oldest packet; other engines wait their turn.
  always_comb begin
    m_data_o = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (w_head_oh[k]) m_data_o = eng_rdata_i[k*DATA_W +: DATA_W];
    end
  end

  assign m_valid_o    = !w_empty && |(eng_rvalid_i & w_head_oh);
  assign m_sop_o      = !w_empty && |(eng_rsop_i & w_head_oh);
  assign m_eop_o      = !w_empty && |(eng_reop_i & w_head_oh);
  assign eng_rready_o = w_empty ? '0 : (w_head_oh & {NUM_ENG{m_ready_i}});
  assign w_pop        = m_valid_o && m_ready_i && m_eop_o;

endmodule
`default_nettype wire
